// File: rtl/ddr_sa_cal_pkg.sv
// Shared types and trim mapping for the 2-phase sense-amp offset calibration engine.
package ddr_sa_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_DONE
  } cal_state_e;

  localparam logic        ZERO_TRIM_DIR  = 1'b0;
  localparam int unsigned ZERO_TRIM_CODE = 0;

  // Sweep runs from the most negative trim (dir=1, code=N-1) up to the most positive.
  function automatic logic trim_dir(input int unsigned idx, input int unsigned n);
    return (idx < n);
  endfunction

  function automatic int unsigned trim_code(input int unsigned idx, input int unsigned n);
    return (idx < n) ? (n - 1 - idx) : (idx - n);
  endfunction

endpackage

// File: rtl/ddr_sa_cal_phase.sv
// Per-phase slice: input synchronizer, majority vote, reference/lock tracking and held trim.
module ddr_sa_cal_phase
  import ddr_sa_cal_pkg::*;
#(
  parameter int CAL_W   = 4,
  parameter int NSAMP_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sa_data,
  input  logic             i_start,
  input  logic             i_track,
  input  logic             i_clr_votes,
  input  logic             i_sample,
  input  logic             i_eval,
  input  logic             i_first,
  input  logic             i_finish,
  input  logic             i_trim_dir,
  input  logic [CAL_W-1:0] i_trim_code,
  output logic             o_lock_d,
  output logic             o_dir,
  output logic [CAL_W-1:0] o_code,
  output logic             o_err
);

  localparam logic [NSAMP_W:0] HALF = (NSAMP_W+1)'(2**(NSAMP_W-1));

  logic               sync1_q, sync2_q;
  logic [NSAMP_W:0]   ones_q, ones_d;
  logic               ref_q, ref_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic               dir_q, dir_d;
  logic [CAL_W-1:0]   code_q, code_d;
  logic               maj;

  always_ff @(posedge i_clk) begin
    sync1_q <= i_sa_data;
    sync2_q <= sync1_q;
    ones_q  <= ones_d;
  end

  // A tie is not a majority, so it resolves to 0.
  assign maj = (ones_q > HALF);

  always_comb begin
    ones_d = ones_q;
    ref_d  = ref_q;
    lock_d = lock_q;
    err_d  = err_q;
    dir_d  = dir_q;
    code_d = code_q;
    if (i_start) begin
      ref_d  = 1'b0;
      lock_d = 1'b0;
      err_d  = 1'b0;
    end
    if (i_clr_votes) begin
      ones_d = '0;
    end else if (i_sample && sync2_q) begin
      ones_d = ones_q + 1'b1;
    end
    if (i_eval) begin
      if (i_first) begin
        ref_d = maj;
      end else if (!lock_q && (maj != ref_q)) begin
        lock_d = 1'b1;
      end
    end
    if (i_track && !lock_q) begin
      dir_d  = i_trim_dir;
      code_d = i_trim_code;
    end
    if (i_finish && !lock_q) begin
      err_d  = 1'b1;
      dir_d  = ZERO_TRIM_DIR;
      code_d = CAL_W'(ZERO_TRIM_CODE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ref_q  <= 1'b0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
      dir_q  <= 1'b0;
      code_q <= '0;
    end else begin
      ref_q  <= ref_d;
      lock_q <= lock_d;
      err_q  <= err_d;
      dir_q  <= dir_d;
      code_q <= code_d;
    end
  end

  assign o_lock_d = lock_d;
  assign o_dir    = dir_q;
  assign o_code   = code_q;
  assign o_err    = err_q;

endmodule

// File: rtl/ddr_sa_2ph_offset_cal.sv
// Offset-calibration engine for the 2-phase sense amp: shared sweep FSM, index and settle timer.
module ddr_sa_2ph_offset_cal
  import ddr_sa_cal_pkg::*;
#(
  parameter int CAL_W    = 4,
  parameter int NSAMP_W  = 3,
  parameter int SETTLE_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cal_start,
  input  logic [SETTLE_W-1:0] i_settle_cnt,
  input  logic                i_sa_data_0,
  input  logic                i_sa_data_180,
  output logic                o_sa_cal_en,
  output logic [CAL_W-1:0]    o_cal_code_0,
  output logic                o_cal_dir_0,
  output logic [CAL_W-1:0]    o_cal_code_180,
  output logic                o_cal_dir_180,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_0,
  output logic                o_err_180
);

  localparam int unsigned      N         = 2**CAL_W;
  localparam logic [CAL_W:0]   IDX_LAST  = (CAL_W+1)'(2*N-1);
  localparam logic [NSAMP_W-1:0] SAMP_LAST = '1;

  cal_state_e          state_q, state_d;
  logic [CAL_W:0]      idx_q, idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d, settle_load;
  logic [NSAMP_W-1:0]  samp_q, samp_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                start, clr_votes, sample, eval, finish, track;
  logic                lock0_d, lock180_d;
  logic                trim_dir_w;
  logic [CAL_W-1:0]    trim_code_w;

  assign settle_load = (i_settle_cnt == '0) ? SETTLE_W'(1) : i_settle_cnt;
  assign trim_dir_w  = trim_dir(32'(idx_q), N);
  assign trim_code_w = CAL_W'(trim_code(32'(idx_q), N));
  assign track       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || (state_q == ST_EVAL);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    samp_d    = samp_q;
    busy_d    = busy_q;
    done_d    = done_q;
    start     = 1'b0;
    clr_votes = 1'b0;
    sample    = 1'b0;
    eval      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cal_start) begin
          state_d  = ST_SETTLE;
          start    = 1'b1;
          idx_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          settle_d = settle_load;
        end
      end
      ST_SETTLE: begin
        if (settle_q <= SETTLE_W'(1)) begin
          state_d   = ST_SAMPLE;
          clr_votes = 1'b1;
          samp_d    = '0;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        samp_d = samp_q + 1'b1;
        if (samp_q == SAMP_LAST) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        eval = 1'b1;
        if ((lock0_d && lock180_d) || (idx_q == IDX_LAST)) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          settle_d = settle_load;
          state_d  = ST_SETTLE;
        end
      end
      ST_DONE: begin
        finish  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      samp_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  ddr_sa_cal_phase #(.CAL_W(CAL_W), .NSAMP_W(NSAMP_W)) u_phase_0 (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sa_data   (i_sa_data_0),
    .i_start     (start),
    .i_track     (track),
    .i_clr_votes (clr_votes),
    .i_sample    (sample),
    .i_eval      (eval),
    .i_first     (idx_q == '0),
    .i_finish    (finish),
    .i_trim_dir  (trim_dir_w),
    .i_trim_code (trim_code_w),
    .o_lock_d    (lock0_d),
    .o_dir       (o_cal_dir_0),
    .o_code      (o_cal_code_0),
    .o_err       (o_err_0)
  );

  ddr_sa_cal_phase #(.CAL_W(CAL_W), .NSAMP_W(NSAMP_W)) u_phase_180 (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sa_data   (i_sa_data_180),
    .i_start     (start),
    .i_track     (track),
    .i_clr_votes (clr_votes),
    .i_sample    (sample),
    .i_eval      (eval),
    .i_first     (idx_q == '0),
    .i_finish    (finish),
    .i_trim_dir  (trim_dir_w),
    .i_trim_code (trim_code_w),
    .o_lock_d    (lock180_d),
    .o_dir       (o_cal_dir_180),
    .o_code      (o_cal_code_180),
    .o_err       (o_err_180)
  );

  assign o_sa_cal_en = busy_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_ddr_sa_2ph_offset_cal.sv
// Directed bench for ddr_sa_2ph_offset_cal with a behavioural sense-amp model per phase.
module tb_ddr_sa_2ph_offset_cal;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] settle = 8'd4;
  logic       sa0, sa180;
  logic       cal_en, dir0, dir180, busy, done, err0, err180;
  logic [3:0] code0, code180;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  // SA model mode: 0 threshold on sweep index, 1 const 1, 2 const 0, 3 noisy (5/8 at idx0, 4/8 after)
  int mode0 = 2, thr0 = 0, mode180 = 2, thr180 = 0;

  typedef struct {
    int settle;
    int m0;  int t0;
    int m180; int t180;
    int steps;
    int d0;  int c0;
    int d180; int c180;
    int e0;  int e180;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  function automatic logic sa_model(input int m, input int t, input logic d,
                                    input logic [3:0] c, input int cy);
    int k;
    k = d ? (15 - int'(c)) : (16 + int'(c));
    case (m)
      0:       return (k >= t);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return (k == 0) ? ((cy % 8) < 5) : ((cy % 8) < 4);
    endcase
  endfunction

  assign sa0   = sa_model(mode0, thr0, dir0, code0, cyc);
  assign sa180 = sa_model(mode180, thr180, dir180, code180, cyc);

  ddr_sa_2ph_offset_cal dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cal_start    (start),
    .i_settle_cnt   (settle),
    .i_sa_data_0    (sa0),
    .i_sa_data_180  (sa180),
    .o_sa_cal_en    (cal_en),
    .o_cal_code_0   (code0),
    .o_cal_dir_0    (dir0),
    .o_cal_code_180 (code180),
    .o_cal_dir_180  (dir180),
    .o_busy         (busy),
    .o_done         (done),
    .o_err_0        (err0),
    .o_err_180      (err180)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cal_en"}, int'(cal_en), 0);
    check({tag, " busy"},   int'(busy),   0);
    check({tag, " done"},   int'(done),   0);
    check({tag, " trim0"},  int'({dir0, code0}), 0);
    check({tag, " trim180"}, int'({dir180, code180}), 0);
    check({tag, " errs"},   int'({err0, err180}), 0);
  endtask

  // Runs one calibration; injects a start pulse mid-run and another on the DONE cycle.
  task automatic run_cal(input vec_t v, input string tag);
    int total;
    total   = v.steps * (((v.settle == 0) ? 1 : v.settle) + 9);
    settle  = 8'(v.settle);
    mode0   = v.m0;   thr0   = v.t0;
    mode180 = v.m180; thr180 = v.t180;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy at start"}, int'(busy), 1);
    check({tag, " done cleared"}, int'(done), 0);
    for (int i = 1; i <= total; i++) begin
      @(posedge clk); #1;
      if (i == 5) check({tag, " cal_en mid"}, int'(cal_en), 1);
      start = (i == 10);
    end
    check({tag, " done not early"}, int'(done), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " done"},    int'(done),    1);
    check({tag, " busy"},    int'(busy),    0);
    check({tag, " cal_en"},  int'(cal_en),  0);
    check({tag, " dir0"},    int'(dir0),    v.d0);
    check({tag, " code0"},   int'(code0),   v.c0);
    check({tag, " dir180"},  int'(dir180),  v.d180);
    check({tag, " code180"}, int'(code180), v.c180);
    check({tag, " err0"},    int'(err0),    v.e0);
    check({tag, " err180"},  int'(err180),  v.e180);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " stays idle"}, int'({busy, done}), 1);
  endtask

  initial begin
    //          settle m0 t0  m180 t180 steps d0 c0  d180 c180 e0 e180
    vecs[0] = '{4,     0, 19, 0,   20,  21,   0, 3,  0,   4,   0, 0};
    vecs[1] = '{4,     0, 5,  0,   5,   6,    1, 10, 1,   10,  0, 0};
    vecs[2] = '{4,     0, 9,  1,   0,   32,   1, 6,  0,   0,   0, 1};
    vecs[3] = '{4,     3, 0,  0,   3,   4,    1, 14, 1,   12,  0, 0};
    vecs[4] = '{1,     0, 2,  0,   3,   4,    1, 13, 1,   12,  0, 0};
    vecs[5] = '{0,     0, 2,  0,   3,   4,    1, 13, 1,   12,  0, 0};
    vecs[6] = '{2,     2, 0,  1,   0,   32,   0, 0,  0,   0,   1, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    for (int i = 0; i < 7; i++) begin
      run_cal(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while sampling at idx 7, then a clean recalibration.
    settle = 8'd4;
    mode0 = 0; thr0 = 20; mode180 = 0; thr180 = 20;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 98; i++) begin
      @(posedge clk); #1;
      if (i == 93) check("idx7 trim0", int'({dir0, code0}), 16 + 8);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midrun reset");
    @(posedge clk); #1;
    check("post reset idle", int'(busy), 0);
    run_cal('{4, 0, 12, 0, 25, 26, 1, 3, 0, 9, 0, 0}, "recal");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
